// File: rtl/pool_pkg.sv
// pool_pkg: shared pooling mode constants and counter-width helper
package pool_pkg;
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pool2x2_lane.sv
// pool2x2_lane: one channel of stride-2 2x2 max/average pooling with line buffer
module pool2x2_lane
  import pool_pkg::*;
#(
  parameter int DW = 8,
  parameter int IN_W = 6,
  parameter int SIGNED = 0,
  parameter int IW = cw(IN_W/2)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic                    col_odd,
  input  logic                    row_odd,
  input  logic                    avg,
  input  logic [IW-1:0]           idx,
  input  logic [DW-1:0]           pixel,
  output logic [DW-1:0]           out_data,
  output logic [(IN_W/2)*DW-1:0]  pool_lin
);
  logic [DW-1:0] hold, res;
  logic [DW:0]   lbuf [IN_W/2];
  logic [DW:0]   hx, px, h, lb;
  logic [DW+1:0] vh, vl;
  // Horizontal pair combine, then vertical combine against the buffered row; values are
  // widened with sign or zero fill so a single signed compare serves both number formats
  always_comb begin
    hx  = (SIGNED != 0) ? {hold[DW-1], hold} : {1'b0, hold};
    px  = (SIGNED != 0) ? {pixel[DW-1], pixel} : {1'b0, pixel};
    h   = avg ? hx + px : ($signed(hx) > $signed(px) ? hx : px);
    lb  = lbuf[idx];
    vh  = (SIGNED != 0) ? {h[DW], h} : {1'b0, h};
    vl  = (SIGNED != 0) ? {lb[DW], lb} : {1'b0, lb};
    res = avg ? DW'((vh + vl) >> 2) : ($signed(vh) > $signed(vl) ? h[DW-1:0] : lb[DW-1:0]);
  end
  // Hold even-column pixels, buffer even-row pairs, register pooled results on odd/odd beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      out_data <= '0;
      pool_lin <= '0;
      for (int k = 0; k < IN_W/2; k++) lbuf[k] <= '0;
    end else if (vld) begin
      if (!col_odd) hold <= pixel;
      else if (!row_odd) lbuf[idx] <= h;
      else begin
        out_data <= res;
        for (int k = 0; k < IN_W/2; k++)
          if (idx == IW'(k)) pool_lin[k*DW +: DW] <= res;
      end
    end
  end
endmodule

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: CH-channel raster stream 2x2 stride-2 pooling with row/frame strobes
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int CH = 3,
  parameter int DW = 8,
  parameter int IN_W = 6,
  parameter int IN_H = 6,
  parameter int SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic                       mode,
  input  logic [CH*DW-1:0]           conv_in,
  output logic                       out_vld,
  output logic [CH*DW-1:0]           out_data,
  output logic [CH*(IN_W/2)*DW-1:0]  pool_lin,
  output logic                       row_vld,
  output logic                       frame_done
);
  localparam int CW = cw(IN_W);
  localparam int RW = cw(IN_H);
  localparam int IW = cw(IN_W/2);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          mode_q, first, avg, last_col, last_row, fire;
  logic [IW-1:0] idx;
  // Position decode; the first beat of a frame uses the live mode input directly
  always_comb begin
    first    = (col == '0) && (row == '0);
    avg      = (first ? mode : mode_q) == POOL_AVG;
    last_col = col == CW'(IN_W-1);
    last_row = row == RW'(IN_H-1);
    fire     = in_vld & col[0] & row[0];
    idx      = IW'(col >> 1);
  end
  // Raster counters and frame mode latch, advancing only on valid beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
    end else if (in_vld) begin
      if (first) mode_q <= mode;
      col <= last_col ? '0 : col + 1'b1;
      if (last_col) row <= last_row ? '0 : row + 1'b1;
    end
  end
  // Output strobes aligned with the registered pooled pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld    <= 1'b0;
      row_vld    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_vld    <= fire;
      row_vld    <= fire & last_col;
      frame_done <= fire & last_col & last_row;
    end
  end
  for (genvar c = 0; c < CH; c++) begin : g_lane
    pool2x2_lane #(.DW(DW), .IN_W(IN_W), .SIGNED(SIGNED), .IW(IW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld      (in_vld),
      .col_odd  (col[0]),
      .row_odd  (row[0]),
      .avg      (avg),
      .idx      (idx),
      .pixel    (conv_in[c*DW +: DW]),
      .out_data (out_data[c*DW +: DW]),
      .pool_lin (pool_lin[c*(IN_W/2)*DW +: (IN_W/2)*DW])
    );
  end
endmodule
